// File: rtl/cpu_pkg.sv
// Shared encodings for the core sequencer: FSM states, PC source select,
// ARM condition codes and NZCV bit positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd7
    } state_e;

    localparam logic [1:0] PCSEL_SEQ = 2'd0;
    localparam logic [1:0] PCSEL_BR  = 2'd1;
    localparam logic [1:0] PCSEL_REG = 2'd2;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

endpackage

// File: rtl/cpu_seq_ctrl_cond_eval.sv
// Combinational ARM condition evaluator: (flags, condition code) -> taken.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] i_nzcv,
    input  logic [3:0] i_cond,
    output logic       o_taken
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_nzcv[NZCV_N];
    assign w_z = i_nzcv[NZCV_Z];
    assign w_c = i_nzcv[NZCV_C];
    assign w_v = i_nzcv[NZCV_V];

    always_comb begin
        // NOTE: default before the case so every path assigns o_taken; no latch.
        o_taken = 1'b0;
        case (i_cond)
            COND_EQ: o_taken = w_z;
            COND_NE: o_taken = !w_z;
            COND_CS: o_taken = w_c;
            COND_CC: o_taken = !w_c;
            COND_MI: o_taken = w_n;
            COND_PL: o_taken = !w_n;
            COND_VS: o_taken = w_v;
            COND_VC: o_taken = !w_v;
            COND_HI: o_taken = w_c && !w_z;
            COND_LS: o_taken = !w_c || w_z;
            COND_GE: o_taken = (w_n == w_v);
            COND_LT: o_taken = (w_n != w_v);
            COND_GT: o_taken = !w_z && (w_n == w_v);
            COND_LE: o_taken = w_z || (w_n != w_v);
            COND_AL: o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning the NZCV flags and all
// datapath write enables. Define CPU_SEQ_PERF_EN to add CYCLE_CNT/INSTRET.
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REGWRITE,
    input  logic       MEMRW,
    input  logic       MEMTOREG,
    input  logic       R_BRANCH,
    input  logic       C_BRANCH,
    input  logic [3:0] COND,
    input  logic [3:0] NZCVWRITE,
    input  logic [3:0] ALU_NZCV,
    input  logic       IMEM_READY,
    input  logic       DMEM_READY,
    output logic       IMEM_REQ,
    output logic       DMEM_REQ,
    output logic       DMEM_WE,
    output logic       IR_WE,
    output logic       PC_WE,
    output logic [1:0] PC_SEL,
    output logic       REG_WE,
    output logic [3:0] NZCV,
    output logic [2:0] STATE,
    output logic       INSTR_DONE,
`ifdef CPU_SEQ_PERF_EN
    output logic       FAULT,
    output logic [31:0] CYCLE_CNT,
    output logic [31:0] INSTRET
`else
    output logic       FAULT
`endif
);

    localparam bit              TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_e          r_state;
    logic [3:0]      r_nzcv;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_taken;
    logic            w_to_hit;

    cond_eval u_cond (
        .i_nzcv  (r_nzcv),
        .i_cond  (COND),
        .o_taken (w_taken)
    );

    assign w_to_hit = TO_EN && (r_to_cnt == TO_LAST);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= ST_FETCH;
            r_nzcv   <= 4'b0000;
            r_to_cnt <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (IMEM_READY) begin
                        r_state <= ST_DECODE;
                    end else if (w_to_hit) begin
                        r_state <= ST_FAULT;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_DECODE: r_state <= ST_EXEC;
                ST_EXEC: begin
                    r_nzcv <= (r_nzcv & ~NZCVWRITE) | (ALU_NZCV & NZCVWRITE);
                    if (MEMRW || MEMTOREG) begin
                        r_state  <= ST_MEM;
                        r_to_cnt <= '0;
                    end else if (REGWRITE) begin
                        r_state <= ST_WB;
                    end else begin
                        r_state  <= ST_FETCH;
                        r_to_cnt <= '0;
                    end
                end
                ST_MEM: begin
                    // READY checked first so it wins over the terminal count.
                    if (DMEM_READY) begin
                        if (MEMTOREG) begin
                            r_state <= ST_WB;
                        end else begin
                            r_state  <= ST_FETCH;
                            r_to_cnt <= '0;
                        end
                    end else if (w_to_hit) begin
                        r_state <= ST_FAULT;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_WB: begin
                    r_state  <= ST_FETCH;
                    r_to_cnt <= '0;
                end
                ST_FAULT: r_state <= ST_FAULT;
                default:  r_state <= ST_FAULT;
            endcase
        end
    end

    // Enables must follow READY within the cycle and drop the instant RST
    // rises, so they are decoded from state rather than registered.
    always_comb begin
        IMEM_REQ   = 1'b0;
        DMEM_REQ   = 1'b0;
        DMEM_WE    = 1'b0;
        IR_WE      = 1'b0;
        PC_WE      = 1'b0;
        PC_SEL     = PCSEL_SEQ;
        REG_WE     = 1'b0;
        INSTR_DONE = 1'b0;
        if (!RST) begin
            case (r_state)
                ST_FETCH: begin
                    IMEM_REQ = 1'b1;
                    IR_WE    = IMEM_READY;
                end
                ST_EXEC: begin
                    PC_WE = 1'b1;
                    if (R_BRANCH) begin
                        PC_SEL = PCSEL_REG;
                    end else if (C_BRANCH && w_taken) begin
                        PC_SEL = PCSEL_BR;
                    end
                    INSTR_DONE = !(MEMRW || MEMTOREG) && !REGWRITE;
                end
                ST_MEM: begin
                    DMEM_REQ   = 1'b1;
                    DMEM_WE    = MEMRW;
                    INSTR_DONE = DMEM_READY && !MEMTOREG;
                end
                ST_WB: begin
                    REG_WE     = 1'b1;
                    INSTR_DONE = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign NZCV  = r_nzcv;
    assign STATE = r_state;
    assign FAULT = (r_state == ST_FAULT);

`ifdef CPU_SEQ_PERF_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cycle_cnt <= '0;
            r_instret   <= '0;
        end else begin
            if (r_state != ST_FAULT) r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (INSTR_DONE)          r_instret   <= r_instret + 32'd1;
        end
    end

    assign CYCLE_CNT = r_cycle_cnt;
    assign INSTRET   = r_instret;
`endif

endmodule
